// File: rtl/gate_tt_pkg.sv
// Shared encodings for the gate truth-table checker: gate selects, reference
// tables and the sequencer state type.
package gate_tt_pkg;

  typedef enum logic [2:0] {
    SEL_AND  = 3'd0,
    SEL_OR   = 3'd1,
    SEL_NOTA = 3'd2,
    SEL_NAND = 3'd3,
    SEL_NOR  = 3'd4,
    SEL_XOR  = 3'd5,
    SEL_XNOR = 3'd6,
    SEL_RSVD = 3'd7
  } gate_sel_e;

  // Table bit i holds y for a=i[1], b=i[0]
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOTA = 4'b0011;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam logic [2:0] NO_MATCH = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [3:0] tt;
  } exp_tt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_e;

  function automatic exp_tt_t exp_tt(input logic [2:0] sel);
    exp_tt_t r;
    r.valid = 1'b1;
    case (sel)
      SEL_AND:  r.tt = TT_AND;
      SEL_OR:   r.tt = TT_OR;
      SEL_NOTA: r.tt = TT_NOTA;
      SEL_NAND: r.tt = TT_NAND;
      SEL_NOR:  r.tt = TT_NOR;
      SEL_XOR:  r.tt = TT_XOR;
      SEL_XNOR: r.tt = TT_XNOR;
      default: begin
        r.valid = 1'b0;
        r.tt    = 4'b0000;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_tt_checker_if.sv
// Control, result and gate-under-test signals of the truth-table checker.
// slave = checker side, master = driver / gate side.
interface gate_tt_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic [2:0]       exp_sel;
  logic             dut_a;
  logic             dut_b;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       tt_obs;
  logic             match_valid;
  logic [2:0]       match_id;
  logic [ERR_W-1:0] err_cnt;

  modport slave (
    input  start, exp_sel, dut_y,
    output dut_a, dut_b, busy, done, pass, tt_obs, match_valid, match_id, err_cnt
  );

  modport master (
    output start, exp_sel, dut_y,
    input  dut_a, dut_b, busy, done, pass, tt_obs, match_valid, match_id, err_cnt
  );
endinterface

// File: rtl/gate_tt_classify.sv
// Combinational classifier: names the first known gate (encoding 0..6) whose
// reference table equals the observed table.
module gate_tt_classify
  import gate_tt_pkg::*;
(
  input  logic [3:0] tt,
  output logic       match_valid,
  output logic [2:0] match_id
);

  exp_tt_t cand;

  // Scan downward so the lowest matching encoding is the one left standing
  always_comb begin
    match_valid = 1'b0;
    match_id    = NO_MATCH;
    cand        = '0;
    for (int i = 6; i >= 0; i--) begin
      cand = exp_tt(3'(i));
      if (tt == cand.tt) begin
        match_valid = 1'b1;
        match_id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Clocked stimulus-and-capture harness for a 2-input gate: sweeps the four
// input vectors, captures the truth table, checks and classifies it.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 8
) (
  input logic              clk,
  input logic              rst,
  gate_tt_checker_if.slave tt_if
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             dut_a_q, dut_a_d;
  logic             dut_b_q, dut_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       tt_obs_q, tt_obs_d;
  logic             match_valid_q, match_valid_d;
  logic [2:0]       match_id_q, match_id_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  exp_tt_t          exp_w;
  logic             cls_valid;
  logic [2:0]       cls_id;

  assign exp_w = exp_tt(sel_q);

  gate_tt_classify u_classify (
    .tt          (tt_obs_q),
    .match_valid (cls_valid),
    .match_id    (cls_id)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    dut_a_d       = dut_a_q;
    dut_b_d       = dut_b_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    tt_obs_d      = tt_obs_q;
    match_valid_d = match_valid_q;
    match_id_d    = match_id_q;
    err_cnt_d     = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (tt_if.start) begin
          sel_d              = tt_if.exp_sel;
          idx_d              = 2'd0;
          cnt_d              = 4'd0;
          {dut_a_d, dut_b_d} = 2'b00;
          busy_d             = 1'b1;
          state_d            = RUN;
        end
      end
      RUN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d           = 4'd0;
          tt_obs_d[idx_q] = tt_if.dut_y;
          if (idx_q == 2'd3) begin
            {dut_a_d, dut_b_d} = 2'b00;
            state_d            = CHECK;
          end else begin
            idx_d              = idx_q + 2'd1;
            {dut_a_d, dut_b_d} = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        pass_d        = exp_w.valid && (tt_obs_q == exp_w.tt);
        match_valid_d = cls_valid;
        match_id_d    = cls_id;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        if (!pass_d && (err_cnt_q != '1))
          err_cnt_d = err_cnt_q + ERR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      cnt_q         <= 4'd0;
      sel_q         <= 3'd0;
      dut_a_q       <= 1'b0;
      dut_b_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      tt_obs_q      <= 4'd0;
      match_valid_q <= 1'b0;
      match_id_q    <= NO_MATCH;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      dut_a_q       <= dut_a_d;
      dut_b_q       <= dut_b_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      tt_obs_q      <= tt_obs_d;
      match_valid_q <= match_valid_d;
      match_id_q    <= match_id_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign tt_if.dut_a       = dut_a_q;
  assign tt_if.dut_b       = dut_b_q;
  assign tt_if.busy        = busy_q;
  assign tt_if.done        = done_q;
  assign tt_if.pass        = pass_q;
  assign tt_if.tt_obs      = tt_obs_q;
  assign tt_if.match_valid = match_valid_q;
  assign tt_if.match_id    = match_id_q;
  assign tt_if.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: two instances (S=2/ERR_W=8 and
// S=1/ERR_W=2) driven by behavioural gate models.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_tt_checker_if #(.ERR_W(8)) if0 ();
  gate_tt_checker_if #(.ERR_W(2)) if1 ();

  gate_tt_checker #(.SETTLE_CYC(2), .ERR_W(8)) dut0 (.clk(clk), .rst(rst), .tt_if(if0.slave));
  gate_tt_checker #(.SETTLE_CYC(1), .ERR_W(2)) dut1 (.clk(clk), .rst(rst), .tt_if(if1.slave));

  // Gate modes: 0..6 = AND OR NOT(a) NAND NOR XOR XNOR, 7 = const 0, 8 = const 1
  function automatic logic gate_fn(input int m, input logic a, input logic b);
    case (m)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      6: return ~(a ^ b);
      7: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  int mode0 = 0;
  assign if0.dut_y = gate_fn(mode0, if0.dut_a, if0.dut_b);
  assign if1.dut_y = gate_fn(0, if1.dut_a, if1.dut_b);

  localparam logic [3:0] TT_REF [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                                        4'b0001, 4'b0110, 4'b1001};

  typedef struct {
    logic [3:0] tt;
    logic       pass;
    logic       mv;
    logic [2:0] mid;
    int         err;
    int         done_cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int err_m0  = 0;
  int err_m1  = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: evaluate the gate on all four vectors, then apply the check rules
  function automatic exp_t predict(input int mode, input int sel, input int err_prev,
                                   input int err_max, input int done_cyc);
    exp_t r;
    for (int i = 0; i < 4; i++)
      r.tt[i] = gate_fn(mode, (i / 2) % 2 == 1, i % 2 == 1);
    r.pass = (sel < 7) && (r.tt == TT_REF[sel]);
    r.mv   = 1'b0;
    r.mid  = 3'd7;
    for (int i = 0; i < 7; i++)
      if (!r.mv && r.tt == TT_REF[i]) begin
        r.mv  = 1'b1;
        r.mid = 3'(i);
      end
    r.err      = r.pass ? err_prev : ((err_prev + 1 > err_max) ? err_max : err_prev + 1);
    r.done_cyc = done_cyc;
    return r;
  endfunction

  always @(negedge clk) begin
    if (if0.done === 1'b1) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL u0_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("u0_tt_obs", 32'(if0.tt_obs), 32'(e0.tt));
        chk("u0_pass", 32'(if0.pass), 32'(e0.pass));
        chk("u0_match_valid", 32'(if0.match_valid), 32'(e0.mv));
        chk("u0_match_id", 32'(if0.match_id), 32'(e0.mid));
        chk("u0_err_cnt", 32'(if0.err_cnt), 32'(e0.err));
        chk("u0_busy_at_done", 32'(if0.busy), 32'd0);
        chk("u0_latency", 32'(cyc), 32'(e0.done_cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL u1_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("u1_tt_obs", 32'(if1.tt_obs), 32'(e1.tt));
        chk("u1_pass", 32'(if1.pass), 32'(e1.pass));
        chk("u1_match_valid", 32'(if1.match_valid), 32'(e1.mv));
        chk("u1_match_id", 32'(if1.match_id), 32'(e1.mid));
        chk("u1_err_cnt", 32'(if1.err_cnt), 32'(e1.err));
        chk("u1_latency", 32'(cyc), 32'(e1.done_cyc));
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (accept edge)
  task automatic start0(input int mode, input int sel, input bit expect_done);
    exp_t r;
    mode0       = mode;
    if0.exp_sel = 3'(sel);
    if0.start   = 1'b1;
    if (expect_done) begin
      r      = predict(mode, sel, err_m0, 255, cyc + 1 + 9);
      err_m0 = r.err;
      q0.push_back(r);
    end
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  task automatic wait_done0();
    int n = 0;
    while (if0.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (if0.done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL u0_done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic wait_done1();
    int n = 0;
    while (if1.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (if1.done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL u1_done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    if0.start   = 1'b0;
    if0.exp_sel = 3'd0;
    if1.start   = 1'b0;
    if1.exp_sel = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_dut_a", 32'(if0.dut_a), 32'd0);
    chk("rst_dut_b", 32'(if0.dut_b), 32'd0);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk("rst_pass", 32'(if0.pass), 32'd0);
    chk("rst_tt_obs", 32'(if0.tt_obs), 32'd0);
    chk("rst_match_valid", 32'(if0.match_valid), 32'd0);
    chk("rst_match_id", 32'(if0.match_id), 32'd7);
    chk("rst_err_cnt", 32'(if0.err_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start0(5, 5, 1'b1);
    chk("busy_after_accept", 32'(if0.busy), 32'd1);
    wait_done0();
    @(negedge clk);
    start0(3, 0, 1'b1); wait_done0(); @(negedge clk);
    start0(3, 0, 1'b1); wait_done0(); @(negedge clk);
    start0(8, 1, 1'b1); wait_done0(); @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      start0(int'($urandom_range(0, 8)), int'($urandom_range(0, 7)), 1'b1);
      wait_done0();
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Extra start pulses mid-run must be ignored; then a back-to-back run
    start0(2, 2, 1'b1);
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    chk("busy_during_repulse", 32'(if0.busy), 32'd1);
    wait_done0();
    start0(2, 2, 1'b1);
    wait_done0();
    @(negedge clk);

    // Asynchronous reset at edge 4 of a run: abort, no done
    start0(5, 5, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    err_m0 = 0;
    chk("abort_busy", 32'(if0.busy), 32'd0);
    chk("abort_dut_a", 32'(if0.dut_a), 32'd0);
    chk("abort_dut_b", 32'(if0.dut_b), 32'd0);
    chk("abort_tt_obs", 32'(if0.tt_obs), 32'd0);
    chk("abort_err_cnt", 32'(if0.err_cnt), 32'd0);
    chk("abort_match_id", 32'(if0.match_id), 32'd7);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_stays_idle", 32'(if0.busy), 32'd0);

    start0(0, 0, 1'b1);
    wait_done0();
    @(negedge clk);

    // S=1, ERR_W=2 instance: reserved select, counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      exp_t r;
      if1.exp_sel = 3'd7;
      if1.start   = 1'b1;
      r      = predict(0, 7, err_m1, 3, cyc + 1 + 5);
      err_m1 = r.err;
      q1.push_back(r);
      @(negedge clk);
      if1.start = 1'b0;
      wait_done1();
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("u0_queue_drained", 32'(q0.size()), 32'd0);
    chk("u1_queue_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
